// File: rtl/load_align_unit.sv
// Sequential load aligner: one or two aligned bus reads, byte merge, zero/sign extend.
// Define LOAD_ALIGN_SPLIT_EN to service misaligned and word-crossing loads.
module load_align_unit #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_op,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_err
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);
  localparam logic [OB+1:0] NBV = NB[OB+1:0];

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
  } state_t;

  state_t state, state_n;

  logic [OB-1:0] off_q;
  logic [1:0]    sz_q;
  logic          sgn_q;
  logic          cross_q;
  logic [DW-1:0] beat0;

  logic [OB-1:0] off;
  logic [1:0]    d_sz;
  logic          d_sgn;
  logic          d_ill;
  logic          d_cross;
  logic [OB+1:0] d_nb;
  logic [1:0]    d_err;

  function automatic logic [OB+1:0] nbytes(input logic [1:0] sz);
    unique case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return NBV;
    endcase
  endfunction

  assign off = req_addr[OB-1:0];

  // sz: 0 byte, 1 half, 2 word, 3 full bus width
  always_comb begin
    d_sz  = 2'd0;
    d_sgn = 1'b0;
    d_ill = 1'b0;
    case (req_op)
      3'b000: d_sz = 2'd3;
      3'b001: d_sz = 2'd0;
      3'b010: begin d_sz = 2'd0; d_sgn = 1'b1; end
      3'b011: d_sz = 2'd1;
      3'b100: begin d_sz = 2'd1; d_sgn = 1'b1; end
      3'b101: begin d_sz = 2'd2; d_ill = (DW != 64); end
      3'b110: begin d_sz = 2'd2; d_sgn = 1'b1; d_ill = (DW != 64); end
      default: d_ill = 1'b1;
    endcase
    d_nb = nbytes(d_sz);
`ifdef LOAD_ALIGN_SPLIT_EN
    d_cross = ({2'b00, off} + d_nb) > NBV;
    d_err   = d_ill ? 2'b10 : 2'b00;
`else
    // misaligned loads trap; a crossing load is always misaligned
    d_cross = 1'b0;
    d_err   = d_ill ? 2'b10 :
              ((({2'b00, off} & (d_nb - 1'b1)) != '0) ? 2'b01 : 2'b00);
`endif
  end

  logic [DW-1:0]   lo, hi, raw, mask, merged;
  logic [2*DW-1:0] shifted;
  logic            sb;

  always_comb begin
    lo = (state == WAIT1) ? beat0 : mem_rsp_data;
    hi = (state == WAIT1) ? mem_rsp_data : '0;
    shifted = {hi, lo} >> {off_q, 3'b000};
    raw = shifted[DW-1:0];
    unique case (sz_q)
      2'd0:    mask = DW'(8'hFF);
      2'd1:    mask = DW'(16'hFFFF);
      2'd2:    mask = DW'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    sb = |(raw & mask & ~(mask >> 1));
    merged = (raw & mask) | ((sgn_q && sb) ? ~mask : '0);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (req_valid) state_n = (d_err != 2'b00) ? RESP : REQ0;
      REQ0:  if (mem_req_ready) state_n = WAIT0;
      WAIT0: if (mem_rsp_valid) state_n = cross_q ? REQ1 : RESP;
      REQ1:  if (mem_req_ready) state_n = WAIT1;
      WAIT1: if (mem_rsp_valid) state_n = RESP;
      RESP:  if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ0) || (state == REQ1);
  assign rsp_valid     = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      off_q        <= '0;
      sz_q         <= '0;
      sgn_q        <= 1'b0;
      cross_q      <= 1'b0;
      beat0        <= '0;
      mem_req_addr <= '0;
      rsp_data     <= '0;
      rsp_err      <= 2'b00;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (req_valid) begin
          off_q        <= off;
          sz_q         <= d_sz;
          sgn_q        <= d_sgn;
          cross_q      <= d_cross;
          mem_req_addr <= {req_addr[AW-1:OB], {OB{1'b0}}};
          rsp_data     <= '0;
          rsp_err      <= d_err;
        end
        WAIT0: if (mem_rsp_valid) begin
          beat0 <= mem_rsp_data;
          if (cross_q) mem_req_addr <= mem_req_addr + AW'(NB);
          else         rsp_data <= merged;
        end
        WAIT1: if (mem_rsp_valid) rsp_data <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit (DW=32): queued expectations,
// a bus responder and a response monitor check the DUT independently.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  load_align_unit #(.DW(32), .AW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [1:0] e; } rsp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } bus_t;
  rsp_t rq[$];
  bus_t bq[$];

  int total = 0;
  int bad = 0;
  int bus_hs = 0;
  int bus_delay = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [31:0] d);
    bus_t b;
    b.a = a; b.d = d;
    bq.push_back(b);
  endtask

  task automatic exp_rsp(input logic [31:0] d, input logic [1:0] e);
    rsp_t r;
    r.d = d; r.e = e;
    rq.push_back(r);
  endtask

  // bus responder
  initial begin
    bus_t b;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        bus_hs++;
        d = '0;
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: read at %0h, none expected", mem_req_addr);
        end else begin
          b = bq.pop_front();
          check("bus_addr", 64'(mem_req_addr), 64'(b.a));
          d = b.d;
        end
        @(posedge clk);
        repeat (bus_delay) @(posedge clk);
        #1 mem_rsp_valid = 1'b1; mem_rsp_data = d;
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;
      end
    end
  end

  // response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: data %0h err %0h", rsp_data, rsp_err);
        end else begin
          r = rq.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(r.d));
          check("rsp_err", 64'(rsp_err), 64'(r.e));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [2:0] op);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 req_valid = 1'b1; req_addr = a; req_op = op;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int lat);
    int n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    if (lat == 1) check({name, "_nobus"}, 64'(mem_req_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string name, input logic [31:0] a,
                     input logic [2:0] op, input logic [31:0] d,
                     input logic [1:0] e, input int lat);
    exp_rsp(d, e);
    send(a, op);
    wait_rsp(name, lat);
  endtask

  initial begin
    int t;
    int target;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    exp_bus(32'h1000, 32'h80FF1234);
    txn("lb", 32'h1003, 3'b010, 32'hFFFFFF80, 2'b00, 3);
    exp_bus(32'h1000, 32'hBEEF0000);
    txn("lhu", 32'h1002, 3'b011, 32'h0000BEEF, 2'b00, 3);
    exp_bus(32'h1000, 32'h12348001);
    txn("lh", 32'h1000, 3'b100, 32'hFFFF8001, 2'b00, 3);
    exp_bus(32'h1000, 32'h0000A500);
    txn("lbu", 32'h1001, 3'b001, 32'h000000A5, 2'b00, 3);
    exp_bus(32'h2000, 32'hDEADBEEF);
    txn("lw", 32'h2000, 3'b000, 32'hDEADBEEF, 2'b00, 3);
    txn("ill7", 32'h1000, 3'b111, 32'h0, 2'b10, 1);
    txn("ill5", 32'h1000, 3'b101, 32'h0, 2'b10, 1);
    txn("ill6", 32'h1002, 3'b110, 32'h0, 2'b10, 1);

`ifdef LOAD_ALIGN_SPLIT_EN
    exp_bus(32'h1000, 32'h44332211);
    exp_bus(32'h1004, 32'h88776655);
    txn("lw_x", 32'h1001, 3'b000, 32'h55443322, 2'b00, 5);
    exp_bus(32'h1000, 32'h00CDAB00);
    txn("lh_mis", 32'h1001, 3'b100, 32'hFFFFCDAB, 2'b00, 3);
    exp_bus(32'hFFFFFFFC, 32'h11000000);
    exp_bus(32'h00000000, 32'h000000F2);
    txn("lh_wrap", 32'hFFFFFFFF, 3'b100, 32'hFFFFF211, 2'b00, 5);
    exp_bus(32'h1000, 32'hAA000000);
    exp_bus(32'h1004, 32'h000000BB);
    txn("lhu_x", 32'h1003, 3'b011, 32'h0000BBAA, 2'b00, 5);
`else
    txn("lw_mis", 32'h1001, 3'b000, 32'h0, 2'b01, 1);
    txn("lh_mis", 32'h1001, 3'b100, 32'h0, 2'b01, 1);
    txn("lh_wrap", 32'hFFFFFFFF, 3'b100, 32'h0, 2'b01, 1);
    txn("lhu_x", 32'h1003, 3'b011, 32'h0, 2'b01, 1);
`endif

    // bus and consumer backpressure
    exp_bus(32'h1000, 32'h7FFF0000);
    exp_rsp(32'h00007FFF, 2'b00);
    mem_req_ready = 1'b0;
    rsp_ready = 1'b0;
    send(32'h1002, 3'b011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_mem_valid", 64'(mem_req_valid), 64'd1);
      check("bp_mem_addr", 64'(mem_req_addr), 64'h1000);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 mem_req_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 2; i++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data", 64'(rsp_data), 64'h7FFF);
      check("hold_err", 64'(rsp_err), 64'd0);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset while a read is outstanding; the late beat must be ignored
    bus_delay = 5;
`ifdef LOAD_ALIGN_SPLIT_EN
    exp_bus(32'h1000, 32'h44332211);
    exp_bus(32'h1004, 32'h88776655);
    target = bus_hs + 2;
    send(32'h1001, 3'b000);
`else
    exp_bus(32'h1000, 32'h000000FF);
    target = bus_hs + 1;
    send(32'h1000, 3'b010);
`endif
    t = 0;
    while (bus_hs < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach_read", 64'(bus_hs), 64'(target));
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("ar_req_ready", 64'(req_ready), 64'd1);
    check("ar_mem_valid", 64'(mem_req_valid), 64'd0);
    check("ar_mem_addr", 64'(mem_req_addr), 64'd0);
    check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    check("ar_rsp_data", 64'(rsp_data), 64'd0);
    check("ar_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stray_rsp_valid", 64'(rsp_valid), 64'd0);
      check("stray_mem_valid", 64'(mem_req_valid), 64'd0);
    end
    bus_delay = 0;

    exp_bus(32'h1000, 32'h0000007F);
    txn("recover", 32'h1000, 3'b001, 32'h0000007F, 2'b00, 3);

    t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rsp_queue_empty", 64'(rq.size()), 64'd0);
    check("bus_queue_empty", 64'(bq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
